// File: rtl/pfclk_rx_align_checker.sv
// pfclk_rx_align_checker: finds the rotation of the PF clock pattern in the recovered
// 20-bit word, qualifies lock, and counts pattern errors and lock losses.
module pfclk_rx_align_checker #(
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4,
  parameter int ERR_W        = 16
) (
  input  logic             clk_link,
  input  logic             reset_n,
  input  logic [19:0]      rx_data,
  input  logic             rx_data_valid,
  input  logic             err_clear,
  output logic             locked,
  output logic [3:0]       phase,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       lock_loss_count,
  output logic             lock_lost
);
  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;
  localparam logic [9:0] BASE     = 10'b0000011111;
  localparam logic [7:0] LC       = 8'(LOCK_COUNT);
  localparam logic [7:0] UC       = 8'(UNLOCK_COUNT);

  function automatic logic [19:0] pat(input int r);
    for (int i = 0; i < 20; i++) pat[i] = BASE[(i + r) % 10];
  endfunction

  logic [19:0]      r_data;
  logic             r_valid;
  logic [1:0]       r_state;
  logic [7:0]       r_good;
  logic [7:0]       r_bad;
  logic [3:0]       r_phase;
  logic             r_locked;
  logic [ERR_W-1:0] r_err;
  logic [7:0]       r_loss;
  logic             r_lost;
  logic [9:0]       w_hit;
  logic [3:0]       w_first;
  logic             w_match;
  logic [7:0]       w_good_nx;
  logic [7:0]       w_bad_nx;

  for (genvar g = 0; g < 10; g++) begin : g_hit
    assign w_hit[g] = r_data == pat(g);
  end

  always_comb begin
    w_first = 4'd0;
    for (int i = 9; i >= 0; i--) if (w_hit[i]) w_first = 4'(i);
  end

  assign w_match   = w_hit[r_phase];
  assign w_good_nx = r_good + 8'd1;
  assign w_bad_nx  = r_bad + 8'd1;

  always_ff @(posedge clk_link) begin
    if (!reset_n) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_state  <= S_SEARCH;
      r_good   <= '0;
      r_bad    <= '0;
      r_phase  <= '0;
      r_locked <= 1'b0;
      r_err    <= '0;
      r_loss   <= '0;
      r_lost   <= 1'b0;
    end else begin
      r_data  <= rx_data;
      r_valid <= rx_data_valid;
      if (!r_valid) begin
        r_state  <= S_SEARCH;
        r_good   <= '0;
        r_bad    <= '0;
        r_locked <= 1'b0;
        if (r_state == S_LOCKED) begin
          r_loss <= r_loss + 8'(r_loss != 8'hFF);
          r_lost <= 1'b1;
        end
      end else if (r_state == S_SEARCH) begin
        if (|w_hit) begin
          r_phase  <= w_first;
          r_good   <= 8'd1;
          r_bad    <= '0;
          r_state  <= LC == 8'd1 ? S_LOCKED : S_VERIFY;
          r_locked <= LC == 8'd1;
        end
      end else if (r_state == S_VERIFY) begin
        // a foreign word only aborts verification; it is not adopted as the next candidate
        r_good <= w_match ? w_good_nx : 8'd0;
        if (!w_match) r_state <= S_SEARCH;
        else if (w_good_nx == LC) begin
          r_state  <= S_LOCKED;
          r_locked <= 1'b1;
          r_bad    <= '0;
        end
      end else if (w_match) begin
        r_bad <= '0;
      end else begin
        r_err <= r_err + ERR_W'(r_err != '1);
        if (w_bad_nx == UC) begin
          r_state  <= S_SEARCH;
          r_locked <= 1'b0;
          r_good   <= '0;
          r_bad    <= '0;
          r_loss   <= r_loss + 8'(r_loss != 8'hFF);
          r_lost   <= 1'b1;
        end else begin
          r_bad <= w_bad_nx;
        end
      end
      if (err_clear) begin
        r_err  <= '0;
        r_loss <= '0;
        r_lost <= 1'b0;
      end
    end
  end

  assign locked          = r_locked;
  assign phase           = r_phase;
  assign err_count       = r_err;
  assign lock_loss_count = r_loss;
  assign lock_lost       = r_lost;
endmodule

// File: tb/tb_pfclk_rx_align_checker.sv
// tb_pfclk_rx_align_checker: directed and random stimulus against a word-level reference model.
module tb_pfclk_rx_align_checker;
  localparam int EW = 6;
  localparam int LOCK_N = 16;
  localparam int UNLOCK_N = 4;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic          clk_link = 1'b0;
  logic          reset_n = 1'b0;
  logic [19:0]   rx_data = '0;
  logic          rx_data_valid = 1'b0;
  logic          err_clear = 1'b0;
  logic          locked;
  logic [3:0]    phase;
  logic [EW-1:0] err_count;
  logic [7:0]    lock_loss_count;
  logic          lock_lost;

  int n_tests = 0;
  int n_fail = 0;

  // reference model: word-level lock qualifier, no notion of RTL encoding
  bit          m_lock, m_ver, m_lost;
  int          m_run, m_bad, m_phase, m_err, m_loss;
  logic [19:0] p_d;
  bit          p_v;

  pfclk_rx_align_checker #(.LOCK_COUNT(LOCK_N), .UNLOCK_COUNT(UNLOCK_N), .ERR_W(EW)) dut (
    .clk_link(clk_link), .reset_n(reset_n), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .err_clear(err_clear), .locked(locked), .phase(phase), .err_count(err_count),
    .lock_loss_count(lock_loss_count), .lock_lost(lock_lost)
  );

  always #5 clk_link = ~clk_link;

  function automatic logic [19:0] mpat(input int r);
    logic [19:0] w;
    for (int i = 0; i < 20; i++) w[i] = ((i + r) % 10) < 5;
    return w;
  endfunction

  function automatic int mrot(input logic [19:0] d);
    for (int r = 0; r < 10; r++) if (d == mpat(r)) return r;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mlose();
    if (m_loss < 255) m_loss++;
    m_lost = 1;
  endtask

  task automatic mproc(input logic [19:0] d, input bit v);
    int r;
    r = mrot(d);
    if (!v) begin
      if (m_lock) mlose();
      m_lock = 0; m_ver = 0; m_run = 0; m_bad = 0;
    end else if (m_lock) begin
      if (r == m_phase) m_bad = 0;
      else begin
        if (m_err < ERR_MAX) m_err++;
        m_bad++;
        if (m_bad == UNLOCK_N) begin
          m_lock = 0; m_bad = 0; m_run = 0;
          mlose();
        end
      end
    end else if (m_ver) begin
      if (r == m_phase) begin
        m_run++;
        if (m_run == LOCK_N) begin m_lock = 1; m_ver = 0; m_bad = 0; end
      end else begin
        m_ver = 0; m_run = 0;
      end
    end else if (r >= 0) begin
      m_phase = r; m_run = 1; m_bad = 0;
      if (LOCK_N == 1) m_lock = 1; else m_ver = 1;
    end
  endtask

  function automatic logic [31:0] got_v();
    return {12'b0, locked, phase, err_count, lock_loss_count, lock_lost};
  endfunction

  function automatic logic [31:0] exp_v();
    return {12'b0, m_lock, 4'(m_phase), EW'(m_err), 8'(m_loss), m_lost};
  endfunction

  task automatic step(input logic [19:0] d, input bit v, input bit clr, input bit rn);
    rx_data = d; rx_data_valid = v; err_clear = clr; reset_n = rn;
    @(posedge clk_link);
    if (!rn) begin
      m_lock = 0; m_ver = 0; m_lost = 0;
      m_run = 0; m_bad = 0; m_phase = 0; m_err = 0; m_loss = 0;
      p_v = 0; p_d = '0;
    end else begin
      mproc(p_d, p_v);
      if (clr) begin m_err = 0; m_loss = 0; m_lost = 0; end
      p_d = d; p_v = v;
    end
    #1;
    chk("cycle", got_v(), exp_v());
  endtask

  task automatic run(input logic [19:0] d, input int n);
    for (int i = 0; i < n; i++) step(d, 1, 0, 1);
  endtask

  task automatic rst(input int n);
    for (int i = 0; i < n; i++) step('0, 0, 0, 0);
  endtask

  initial begin
    logic [19:0] p0, p3, bad;
    int cur, kind;
    p0 = 20'h07C1F;
    p3 = mpat(3);
    rst(3);
    chk("reset", got_v(), 32'h0);

    run(p0, 16);
    chk("pre_lock", {31'b0, locked}, 32'd0);
    run(p0, 1);
    chk("lock_p0", {27'b0, locked, phase}, {27'b0, 1'b1, 4'd0});
    chk("lock_p0_err", 32'(err_count), 32'd0);

    for (int k = 0; k < 3; k++) begin
      bad = p0 ^ (20'd1 << $urandom_range(19, 0));
      step(bad, 1, 0, 1);
      run(p0, 3);
    end
    run(p0, 2);
    chk("single_err", {30'b0, locked, lock_lost}, {30'b0, 1'b1, 1'b0});
    chk("single_err_cnt", 32'(err_count), 32'd3);

    step(p0, 1, 1, 1);
    run(20'h00000, 6);
    chk("unlock", {30'b0, locked, lock_lost}, {30'b0, 1'b0, 1'b1});
    chk("unlock_cnt", {24'b0, 2'b0, err_count}, 32'd4);
    chk("unlock_loss", 32'(lock_loss_count), 32'd1);
    run(p0, 18);
    chk("relock", {31'b0, locked}, 32'd1);

    rst(2);
    run(20'hF83E0, 18);
    chk("lock_p5", {27'b0, locked, phase}, {27'b0, 1'b1, 4'd5});
    for (int r = 0; r < 10; r++) begin
      rst(2);
      run(mpat(r), 18);
      chk("lock_rot", {27'b0, locked, phase}, {27'b0, 1'b1, 4'(r)});
    end

    rst(2);
    run(p0, 11);
    step(p3, 1, 0, 1);
    run(p3, 16);
    chk("verify_abort", {31'b0, locked}, 32'd0);
    run(p3, 1);
    chk("verify_p3", {27'b0, locked, phase}, {27'b0, 1'b1, 4'd3});

    step(p3, 1, 1, 1);
    step(p3, 0, 0, 1);
    run(p3, 2);
    chk("valid_drop", {23'b0, locked, lock_loss_count}, {23'b0, 1'b0, 8'd1});
    run(p3, 18);
    step(20'h12345, 1, 0, 1);
    step(p3, 1, 1, 1);
    chk("clear_wins", 32'(err_count), 32'd0);

    for (int k = 0; k < ERR_MAX + 6; k++) begin
      step(20'h00000, 1, 0, 1);
      step(p3, 1, 0, 1);
    end
    chk("err_sat", {25'b0, locked, err_count}, {25'b0, 1'b1, EW'(ERR_MAX)});

    for (int k = 0; k < 258; k++) begin
      run(p0, 18);
      step(p0, 0, 0, 1);
    end
    run(p0, 2);
    chk("loss_sat", {23'b0, lock_lost, lock_loss_count}, {23'b0, 1'b1, 8'hFF});
    step(p0, 1, 1, 1);
    chk("loss_clear", {23'b0, lock_lost, lock_loss_count}, 32'd0);

    cur = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(29, 0) == 0) cur = $urandom_range(9, 0);
      kind = $urandom_range(99, 0);
      bad = kind < 80 ? mpat(cur) : kind < 90 ? mpat(cur) ^ (20'd1 << $urandom_range(19, 0))
          : kind < 95 ? mpat($urandom_range(9, 0)) : 20'($urandom);
      if ($urandom_range(299, 0) == 0) step(bad, 0, 0, 0);
      else step(bad, $urandom_range(49, 0) != 0, $urandom_range(79, 0) == 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
